imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 87 ++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed byte stream into instruction memory
module imem_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_wen,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHECK, DONE, ERR} state_t;

    localparam logic [16:0] MAXW = 17'(MAX_WORDS);

    state_t      state, nxt;
    logic [7:0]  len_hi, dat_hi, x;
    logic [15:0] len, idx, n;
    logic        acc;

    assign acc = byte_valid & byte_ready;
    assign n   = {len_hi, byte_data};

    // next-state decode; outputs are registered from nxt so they line up with the state
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: nxt = start ? LEN_HI : state;
            LEN_HI:          nxt = acc ? LEN_LO : state;
            LEN_LO:          nxt = !acc ? state : (n == 16'd0) ? CHECK : ({1'b0, n} > MAXW) ? ERR : DAT_HI;
            DAT_HI:          nxt = acc ? DAT_LO : state;
            DAT_LO:          nxt = acc ? WRITE : state;
            WRITE:           nxt = (idx + 16'd1 == len) ? CHECK : DAT_HI;
            CHECK:           nxt = !acc ? state : ((x ^ byte_data) == 8'd0) ? DONE : ERR;
            default:         nxt = IDLE;
        endcase
    end

    // state, registered status/handshake outputs, datapath capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 16'h0000;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            len_hi     <= 8'h00;
            dat_hi     <= 8'h00;
            x          <= 8'h00;
            len        <= 16'h0000;
            idx        <= 16'h0000;
        end else begin
            state      <= nxt;
            byte_ready <= nxt inside {LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHECK};
            busy       <= !(nxt inside {IDLE, DONE, ERR});
            mem_wen    <= nxt == WRITE;
            cpu_hold   <= nxt != DONE;
            done       <= nxt == DONE;
            err        <= nxt == ERR;
            if (nxt == WRITE) begin
                mem_addr  <= BASE_ADDR + idx;
                mem_wdata <= {dat_hi, byte_data};
            end
            if (acc) x <= x ^ byte_data;
            if (state == LEN_HI && acc) len_hi <= byte_data;
            if (state == LEN_LO && acc) len <= n;
            if (state == DAT_HI && acc) dat_hi <= byte_data;
            if (state == WRITE) idx <= idx + 16'd1;
            if (state inside {IDLE, DONE, ERR} && start) begin
                x   <= 8'h00;
                idx <= 16'h0000;
            end
        end
    end
endmodule
